// File: rtl/dsp_limb_addsub_seq.sv
// Multi-word adder/subtractor that handles one LIMB_W-bit limb per clock, LSB limb first.
// A single narrow adder and a carry register build W = LIMB_W*NLIMBS-bit results.
module dsp_limb_addsub_seq #(
  parameter int LIMB_W = 16,
  parameter int NLIMBS = 2,
  localparam int W = LIMB_W * NLIMBS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         carryin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] y,
  output logic         carryout,
  output logic         overflow
);

  localparam int IDX_W = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLIMBS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             sub_q;
  logic             c_q;
  logic [IDX_W-1:0] idx;

  logic [LIMB_W-1:0] limb_a;
  logic [LIMB_W-1:0] limb_bop;
  logic [LIMB_W:0]   limb_sum;
  logic              last_limb;

  // Subtraction is a + ~b + ~borrow_in, so the B limb is inverted here and the
  // initial carry is inverted at start.
  assign limb_a    = a_q[idx*LIMB_W +: LIMB_W];
  assign limb_bop  = b_q[idx*LIMB_W +: LIMB_W] ^ {LIMB_W{sub_q}};
  assign limb_sum  = {1'b0, limb_a} + {1'b0, limb_bop} + {{LIMB_W{1'b0}}, c_q};
  assign last_limb = (idx == LAST_IDX);

  // NOTE: operand registers carry no reset; they are only read in RUN, which is
  // always entered through a start that loads them.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_q   <= a;
      b_q   <= b;
      sub_q <= sub;
    end
  end

  // NOTE: every register below is updated with <= so all reads in this block see
  // the pre-edge values, matching the hardware flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      y        <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      idx      <= '0;
      c_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            idx   <= '0;
            c_q   <= sub ^ carryin;
          end
        end
        RUN: begin
          y[idx*LIMB_W +: LIMB_W] <= limb_sum[LIMB_W-1:0];
          c_q <= limb_sum[LIMB_W];
          idx <= idx + 1'b1;
          if (last_limb) begin
            state    <= DONE;
            done     <= 1'b1;
            carryout <= sub_q ^ limb_sum[LIMB_W];
            overflow <= (limb_a[LIMB_W-1] == limb_bop[LIMB_W-1]) &&
                        (limb_sum[LIMB_W-1] != limb_a[LIMB_W-1]);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
